// File: rtl/mul_pkg.sv
// Shared types and constants for the Booth multiplier dispatch front-end.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } mul_state_t;

    localparam int MUL_OP_W  = 32;
    localparam int MUL_RES_W = 64;
    localparam int MUL_LAT   = 2;

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous first-in first-out buffer for operand/tag entries.
// The head is combinational from storage and reads as zero while empty.
module mul_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: all state updates are non-blocking so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mul_dispatch.sv
// Valid/ready front-end for the 2-cycle Booth multiplier: queues tagged
// operand pairs, issues them one at a time and holds each result for downstream.
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [MUL_OP_W-1:0]  i_in_op1,
    input  logic [MUL_OP_W-1:0]  i_in_op2,
    input  logic [TAG_W-1:0]     i_in_tag,
    output logic                 o_mul_en,
    output logic [MUL_OP_W-1:0]  o_mul_op1,
    output logic [MUL_OP_W-1:0]  o_mul_op2,
    input  logic [MUL_RES_W-1:0] i_mul_res,
    input  logic                 i_mul_val,
    input  logic                 i_mul_overflow,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [MUL_RES_W-1:0] o_out_res,
    output logic                 o_out_overflow,
    output logic [TAG_W-1:0]     o_out_tag,
    output logic                 o_busy
);

    localparam int ENTRY_W = 2 * MUL_OP_W + TAG_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FIFO_CAP = CNT_W'(DEPTH);

    mul_state_t           r_state;
    mul_state_t           w_state_next;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_op_avail;
    logic                 w_slot_free;
    logic                 w_capture;
    logic [TAG_W-1:0]     r_tag_q;
    logic                 r_out_valid;
    logic [MUL_RES_W-1:0] r_out_res;
    logic                 r_out_overflow;
    logic [TAG_W-1:0]     r_out_tag;

    // The count is a register, so a pop in this cycle cannot raise ready.
    assign o_in_ready  = (w_fifo_count < FIFO_CAP);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_op_avail  = !w_fifo_empty || w_push;
    assign w_slot_free = !r_out_valid || i_out_ready;

    mul_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({i_in_tag, i_in_op2, i_in_op1}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_mul_op1 = w_head[MUL_OP_W-1:0];
    assign o_mul_op2 = w_head[2*MUL_OP_W-1:MUL_OP_W];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: defaulting every comb output first keeps this block latch-free.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_op_avail && w_slot_free) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_capture) w_state_next = (w_op_avail && i_out_ready) ? ISSUE : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_mul_en  = 1'b0;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ISSUE: begin
                o_mul_en = 1'b1;
                w_pop    = 1'b1;
            end
            WAIT:    w_capture = i_mul_val && w_slot_free;
            default: ;
        endcase
    end

    // A capture refills the slot even if it is being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_q        <= '0;
            r_out_valid    <= 1'b0;
            r_out_res      <= '0;
            r_out_overflow <= 1'b0;
            r_out_tag      <= '0;
        end else begin
            if (r_state == ISSUE) r_tag_q <= w_head[ENTRY_W-1:2*MUL_OP_W];
            if (w_capture) begin
                r_out_valid    <= 1'b1;
                r_out_res      <= i_mul_res;
                r_out_overflow <= i_mul_overflow;
                r_out_tag      <= r_tag_q;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_out_res      = r_out_res;
    assign o_out_overflow = r_out_overflow;
    assign o_out_tag      = r_out_tag;
    assign o_busy         = !w_fifo_empty || (r_state != IDLE) || r_out_valid;

    a_val_after_issue: assert property (@(posedge clk) disable iff (reset)
        $rose(i_mul_val) |-> $past(o_mul_en, MUL_LAT));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        w_fifo_full |-> !w_push);

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench for mul_dispatch with a behavioural 2-cycle multiplier.
module tb_mul_dispatch;

    typedef struct packed {
        logic [63:0] res;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [3:0]  in_tag;
    logic        mul_en;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [63:0] mul_res;
    logic        mul_val;
    logic        mul_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic        out_ovf;
    logic [3:0]  out_tag;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          results_seen = 0;
    int          last_push_cyc = 0;
    int          last_res_cyc = 0;
    logic [63:0] last_res = '0;
    logic        last_ovf = 1'b0;
    logic [3:0]  last_tag = '0;
    exp_t        exp_q[$];
    int          en_cyc_q[$];

    logic        m_pend;
    logic [31:0] m_a;
    logic [31:0] m_b;

    mul_dispatch #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_op1       (in_op1),
        .i_in_op2       (in_op2),
        .i_in_tag       (in_tag),
        .o_mul_en       (mul_en),
        .o_mul_op1      (mul_op1),
        .o_mul_op2      (mul_op2),
        .i_mul_res      (mul_res),
        .i_mul_val      (mul_val),
        .i_mul_overflow (mul_ovf),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_res      (out_res),
        .o_out_overflow (out_ovf),
        .o_out_tag      (out_tag),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ref_prod(a, b);
        return p[63:32] != {32{p[31]}};
    endfunction

    function automatic exp_t ref_entry(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] t);
        exp_t e;
        e.res = ref_prod(a, b);
        e.ovf = ref_ovf(a, b);
        e.tag = t;
        return e;
    endfunction

    // Multiplier model: val clears the cycle after en and rises one cycle later.
    always @(posedge clk) begin
        if (reset) begin
            mul_val <= 1'b0;
            mul_res <= '0;
            mul_ovf <= 1'b0;
            m_pend  <= 1'b0;
        end else if (mul_en) begin
            mul_val <= 1'b0;
            m_pend  <= 1'b1;
            m_a     <= mul_op1;
            m_b     <= mul_op2;
        end else if (m_pend) begin
            mul_val <= 1'b1;
            mul_res <= ref_prod(m_a, m_b);
            mul_ovf <= ref_ovf(m_a, m_b);
            m_pend  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_entry(in_op1, in_op2, in_tag));
                last_push_cyc <= cyc;
            end
            if (mul_en) en_cyc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("sb_res", out_res, exp_q[0].res);
                    check("sb_ovf", out_ovf, exp_q[0].ovf);
                    check("sb_tag", out_tag, exp_q[0].tag);
                    exp_q.pop_front();
                end
                results_seen <= results_seen + 1;
                last_res_cyc <= cyc;
                last_res     <= out_res;
                last_ovf     <= out_ovf;
                last_tag     <= out_tag;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_op1   = a;
        in_op2   = b;
        in_tag   = t;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (results_seen < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, results_seen, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int acc;
        int drop_at;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_en", mul_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single operation: latency and pulse width.
        en_cyc_q.delete();
        base = results_seen;
        send(32'd3, 32'd5, 4'd1);
        wait_results("single_done", base + 1, 20);
        check("single_res", last_res, 64'd15);
        check("single_ovf", last_ovf, 0);
        check("single_tag", last_tag, 4'd1);
        check("single_latency", last_res_cyc - last_push_cyc, 4);
        check("single_en_count", en_cyc_q.size(), 1);
        check("single_en_cycle", en_cyc_q[0] - last_push_cyc, 1);
        @(posedge clk);
        #1;
        check("single_idle_busy", busy, 0);

        // Overflowing product.
        base = results_seen;
        send(32'h0001_0000, 32'h0001_0000, 4'd2);
        wait_results("ovf_done", base + 1, 20);
        check("ovf_res", last_res, 64'h0000_0001_0000_0000);
        check("ovf_flag", last_ovf, 1);

        // Back-to-back stream with the output always ready.
        en_cyc_q.delete();
        base = results_seen;
        for (int k = 0; k < 4; k++) send(32'(k + 1), 32'd7, 4'(k));
        wait_results("b2b_done", base + 4, 40);
        check("b2b_en_count", en_cyc_q.size(), 4);
        for (int i = 0; i < 3; i++) check("b2b_en_spacing", en_cyc_q[i+1] - en_cyc_q[i], 3);
        check("b2b_last_res", last_res, 64'd28);
        check("b2b_last_tag", last_tag, 4'd3);

        // Full FIFO under back-pressure.
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        en_cyc_q.delete();
        base    = results_seen;
        acc     = 0;
        drop_at = -1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_op1 = 32'(acc + 10);
            in_op2 = 32'(acc + 2);
            in_tag = 4'(8 + acc);
            @(negedge clk);
            if (in_ready) acc++;
            else if (drop_at < 0) drop_at = acc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("full_stall_point", drop_at, 5);
        check("full_accepted", acc, 5);
        check("full_in_ready_low", in_ready, 0);
        check("full_single_issue", en_cyc_q.size(), 1);
        check("full_no_delivery", results_seen, base);
        out_ready = 1'b1;
        wait_results("full_drain", base + 5, 80);
        check("full_in_ready_back", in_ready, 1);
        check("full_sb_empty", exp_q.size(), 0);
        check("full_last_tag", last_tag, 4'd12);

        // Reset during the first WAIT cycle drops everything.
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_idle", busy, 0);
        en_cyc_q.delete();
        base = results_seen;
        send(32'd9, 32'd9, 4'd5);
        send(32'd4, 32'd4, 4'd6);
        check("rst_mid_issued", en_cyc_q.size(), 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_no_result", results_seen, base);
        check("rst_mid_no_reissue", en_cyc_q.size(), 1);
        check("rst_mid_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
